// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder.
//   - 2-bit phase encodings {a,b} of the Gray-coded quadrature cycle
//   - next_up / next_down: the phase that follows a given phase when the
//     encoder moves one step up or one step down
//   - DIR_UP / DIR_DOWN values reported on the direction output
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Up cycle: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  // Down cycle: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] next_down(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Ports:
//   clk    - destination clock
//   reset  - asynchronous active-high reset, clears the whole chain
//   d_i    - asynchronous input
//   q_o    - synchronized output, STAGES clk cycles behind d_i
// STAGES must be at least 2.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: turns the encoder phase pair into a step strobe,
// a direction bit, a wrapping position count and illegal-transition flags.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset
//   quad_a   - encoder phase A (asynchronous)
//   quad_b   - encoder phase B (asynchronous)
//   clear    - synchronous clear of count and err_flag
//   step     - one-cycle pulse per legal transition
//   up_down  - direction of the last legal step (1 = up, 0 = down)
//   count    - WIDTH-bit wrapping position
//   err      - one-cycle pulse on a double (illegal) transition
//   err_flag - sticky copy of err
// A pin change shows up on step/up_down/err SYNC_STAGES+1 cycles later.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clear,
  output logic             step,
  output logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             err,
  output logic             err_flag
);

  // Number of cycles after reset during which prev only follows s.
  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int PW           = $clog2(PRIME_CYCLES + 1);
  localparam logic [PW-1:0] PRIME_DONE = PW'(PRIME_CYCLES);

  logic       a_s;
  logic       b_s;
  logic [1:0] s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .d_i   (quad_a),
    .q_o   (a_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d_i   (quad_b),
    .q_o   (b_s)
  );

  assign s = {a_s, b_s};

  logic [1:0]       prev_q;
  logic [PW-1:0]    prime_q,    prime_d;
  logic             step_q,     step_d;
  logic             up_down_q,  up_down_d;
  logic [WIDTH-1:0] count_q,    count_d;
  logic             err_q,      err_d;
  logic             err_flag_q, err_flag_d;
  logic             primed;

  assign primed = (prime_q == PRIME_DONE);

  always_comb begin
    prime_d    = prime_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    up_down_d  = up_down_q;
    count_d    = count_q;
    err_flag_d = err_flag_q;

    if (!primed) begin
      // Synchronizer chain still filling from its reset value; a decode
      // here would see a phantom jump from 00 to the real pin state.
      prime_d = prime_q + PW'(1);
    end else if (s != prev_q) begin
      if (s == next_up(prev_q)) begin
        step_d    = 1'b1;
        up_down_d = DIR_UP;
        count_d   = count_q + WIDTH'(1);
      end else if (s == next_down(prev_q)) begin
        step_d    = 1'b1;
        up_down_d = DIR_DOWN;
        count_d   = count_q - WIDTH'(1);
      end else begin
        // Both phases changed at once: direction is unknowable.
        err_d      = 1'b1;
        err_flag_d = 1'b1;
      end
    end

    // clear overrides the count update and the sticky flag, but the
    // step/err pulses of the same cycle are still reported.
    if (clear) begin
      count_d    = '0;
      err_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= PH_00;
      prime_q    <= '0;
      step_q     <= 1'b0;
      up_down_q  <= DIR_UP;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      prev_q     <= s;
      prime_q    <= prime_d;
      step_q     <= step_d;
      up_down_q  <= up_down_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign step     = step_q;
  assign up_down  = up_down_q;
  assign count    = count_q;
  assign err      = err_q;
  assign err_flag = err_flag_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder (WIDTH=8, SYNC_STAGES=2).
// A reference model treats the pins as positions on a 4-step Gray circle
// and derives step/direction/error from the signed distance moved, using
// pin samples delayed by the decoder latency. Outputs are compared to it
// every cycle; literal expectations pin down the key scenarios.
module tb_quadrature_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
  logic       clear = 1'b0;
  logic       step;
  logic       up_down;
  logic [7:0] count;
  logic       err;
  logic       err_flag;

  int n_vec = 0;
  int n_mis = 0;

  quadrature_decoder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .clear    (clear),
    .step     (step),
    .up_down  (up_down),
    .count    (count),
    .err      (err),
    .err_flag (err_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position of a phase on the Gray circle 00,01,11,10.
  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  logic [1:0] samp[$];
  logic       m_step = 1'b0;
  logic       m_dir = 1'b1;
  logic [7:0] m_count = 8'd0;
  logic       m_err = 1'b0;
  logic       m_flag = 1'b0;

  initial begin
    int n;
    int d;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        samp.delete();
        m_step = 1'b0; m_dir = 1'b1; m_count = 8'd0; m_err = 1'b0; m_flag = 1'b0;
      end else begin
        samp.push_back({quad_a, quad_b});
        m_step = 1'b0;
        m_err  = 1'b0;
        n = samp.size();
        // Edge n reports the move between pin samples taken at edges
        // n-3 and n-2; the first three edges after reset are blind.
        if (n >= 4) begin
          d = (gidx(samp[n-3]) - gidx(samp[n-4]) + 4) % 4;
          if (d == 1) begin
            m_step = 1'b1; m_dir = 1'b1; m_count = m_count + 8'd1;
          end else if (d == 3) begin
            m_step = 1'b1; m_dir = 1'b0; m_count = m_count - 8'd1;
          end else if (d == 2) begin
            m_err = 1'b1; m_flag = 1'b1;
          end
        end
        if (clear) begin
          m_count = 8'd0;
          m_flag  = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("step",     32'(step),     32'(m_step));
    chk("up_down",  32'(up_down),  32'(m_dir));
    chk("count",    32'(count),    32'(m_count));
    chk("err",      32'(err),      32'(m_err));
    chk("err_flag", 32'(err_flag), 32'(m_flag));
  end

  // Pulse counters for the literal checks.
  int step_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk) begin
    if (step === 1'b1) step_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic set_pins(input logic [1:0] v, input int hold);
    @(negedge clk);
    {quad_a, quad_b} = v;
    $display("vec: pins=%b hold=%0d clear=%b", v, hold, clear);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    int e0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_up_down", 32'(up_down), 32'd1);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    // Up sequence
    s0 = step_cnt;
    set_pins(2'b00, 4); set_pins(2'b01, 4); set_pins(2'b11, 4);
    set_pins(2'b10, 4); set_pins(2'b00, 6);
    settle();
    chk("up_steps", 32'(step_cnt - s0), 32'd4);
    chk("up_count", 32'(count), 32'd4);
    chk("up_dir", 32'(up_down), 32'd1);
    chk("up_err_flag", 32'(err_flag), 32'd0);

    // Down sequence
    s0 = step_cnt;
    set_pins(2'b10, 4); set_pins(2'b11, 4); set_pins(2'b01, 4);
    set_pins(2'b00, 6);
    settle();
    chk("dn_steps", 32'(step_cnt - s0), 32'd4);
    chk("dn_count", 32'(count), 32'd0);
    chk("dn_dir", 32'(up_down), 32'd0);

    // Wrap below zero and back
    set_pins(2'b10, 6);
    settle();
    chk("wrap_dn_count", 32'(count), 32'hFF);
    set_pins(2'b00, 6);
    settle();
    chk("wrap_up_count", 32'(count), 32'd0);
    chk("wrap_err_flag", 32'(err_flag), 32'd0);

    // Illegal 00 -> 11 jump
    s0 = step_cnt; e0 = err_cnt;
    set_pins(2'b11, 6);
    settle();
    chk("jump_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("jump_steps", 32'(step_cnt - s0), 32'd0);
    chk("jump_err_flag", 32'(err_flag), 32'd1);
    chk("jump_count", 32'(count), 32'd0);
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    settle();
    chk("clr_err_flag", 32'(err_flag), 32'd0);

    // Seven up steps from 11, then clear coinciding with the eighth
    set_pins(2'b10, 4); set_pins(2'b00, 4); set_pins(2'b01, 4);
    set_pins(2'b11, 4); set_pins(2'b10, 4); set_pins(2'b00, 4);
    set_pins(2'b01, 6);
    settle();
    chk("pre_clr_count", 32'(count), 32'd7);
    @(negedge clk);
    {quad_a, quad_b} = 2'b11;
    $display("vec: pins=11 with clear on decode cycle");
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    settle();
    chk("clrstep_step", 32'(step), 32'd1);
    chk("clrstep_dir", 32'(up_down), 32'd1);
    chk("clrstep_count", 32'(count), 32'd0);
    @(negedge clk) clear = 1'b0;
    repeat (4) @(negedge clk);

    // Reset with pins held at 11: priming must hide the 00->11 fill
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    s0 = step_cnt; e0 = err_cnt;
    repeat (8) @(negedge clk);
    settle();
    chk("prime_steps", 32'(step_cnt - s0), 32'd0);
    chk("prime_errs", 32'(err_cnt - e0), 32'd0);
    chk("prime_count", 32'(count), 32'd0);
    s0 = step_cnt;
    set_pins(2'b10, 6);
    settle();
    chk("post_prime_steps", 32'(step_cnt - s0), 32'd1);
    chk("post_prime_count", 32'(count), 32'd1);
    chk("post_prime_dir", 32'(up_down), 32'd1);

    // Illegal 10 -> 01 sets the flag; then 01 -> 10 with clear on the err cycle
    set_pins(2'b01, 6);
    settle();
    chk("ill_err_flag", 32'(err_flag), 32'd1);
    @(negedge clk);
    {quad_a, quad_b} = 2'b10;
    $display("vec: pins=10 illegal with clear on decode cycle");
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    settle();
    chk("clrerr_err", 32'(err), 32'd1);
    chk("clrerr_err_flag", 32'(err_flag), 32'd0);
    chk("clrerr_count", 32'(count), 32'd0);
    @(negedge clk) clear = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
